alu_op_sequencer: RTL and testbench

- Control and result stage that wraps the registered arithmetic unit (adder and subtractor, 1-cycle registered latency).
- Accepts an opcode and two operands over a valid/ready handshake.
- Drives the AU operand buses, sequences multi-cycle operations, captures the result and Z/N/C/V flags, and presents them downstream over valid/ready.
- Logic ops are computed locally; ADD/SUB/INC/CMP/MUL use the external AU.

---
 rtl/alu_op_sequencer_if.sv | 37 +++
 rtl/alu_op_sequencer.sv | 157 +++++++++++++++
 tb/tb_alu_op_sequencer.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/alu_op_sequencer_if.sv
// Request, AU operand/result and response signals of the ALU op sequencer.
// The slave side is the sequencer; the master side is its environment.
interface alu_op_sequencer_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [WIDTH-1:0] au_in1;
    logic [WIDTH-1:0] au_in2;
    logic [WIDTH-1:0] au_add_out;
    logic             au_add_cout;
    logic [WIDTH-1:0] au_sub_out;
    logic             au_sub_bout;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic [3:0]       res_flags;

    modport slave (
        input  in_valid, in_op, in_a, in_b,
        input  au_add_out, au_add_cout, au_sub_out, au_sub_bout,
        input  res_ready,
        output in_ready, au_in1, au_in2,
        output res_valid, res_data, res_flags
    );

    modport master (
        output in_valid, in_op, in_a, in_b,
        output au_add_out, au_add_cout, au_sub_out, au_sub_bout,
        output res_ready,
        input  in_ready, au_in1, au_in2,
        input  res_valid, res_data, res_flags
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Control/result stage around a registered adder/subtractor unit.
// Operands are latched on accept; work starts on the following edge.
module alu_op_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic reset,
    alu_op_sequencer_if.slave bus
);
    localparam int MSB = WIDTH - 1;
    localparam int IW  = $clog2(WIDTH + 1);
    localparam logic [IW-1:0] I_LAST = IW'(WIDTH);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_INC = 3'b101;
    localparam logic [2:0] OP_CMP = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [2:0] {
        IDLE, ISSUE, WAIT, MUL_ISSUE, MUL_WAIT, DONE
    } state_t;

    state_t           state_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] au_in1_q, au_in2_q;
    logic [WIDTH-1:0] res_data_q;
    logic [3:0]       res_flags_q;
    logic             res_valid_q, in_ready_q;
    logic             wait_q, ovf_q;
    logic [IW-1:0]    i_q;

    logic             is_logic;
    logic [WIDTH-1:0] lg_res;
    logic [WIDTH-1:0] au_res, au_fres;
    logic             au_c, au_v;
    logic [2*WIDTH-1:0] mul_sh;
    logic             mul_first, mul_bit, mul_ovf, mul_ovf_nxt;
    logic [WIDTH-1:0] mul_sum;

    // Local logic result and AU capture/flag selection
    always_comb begin
        is_logic = 1'b0;
        lg_res   = '0;
        au_res   = bus.au_add_out;
        au_fres  = bus.au_add_out;
        au_c     = bus.au_add_cout;
        au_v     = (au_in1_q[MSB] == au_in2_q[MSB]) &&
                   (bus.au_add_out[MSB] != au_in1_q[MSB]);
        case (op_q)
            OP_AND: begin is_logic = 1'b1; lg_res = a_q & b_q; end
            OP_OR:  begin is_logic = 1'b1; lg_res = a_q | b_q; end
            OP_XOR: begin is_logic = 1'b1; lg_res = a_q ^ b_q; end
            OP_SUB, OP_CMP: begin
                au_res  = (op_q == OP_CMP) ? a_q : bus.au_sub_out;
                au_fres = bus.au_sub_out;
                au_c    = bus.au_sub_bout;
                au_v    = (au_in1_q[MSB] != au_in2_q[MSB]) &&
                          (bus.au_sub_out[MSB] != au_in1_q[MSB]);
            end
            default: ;
        endcase
    end

    // Shift-add step: next partial product term and overflow tracking
    always_comb begin
        mul_sh      = {{WIDTH{1'b0}}, a_q} << i_q;
        mul_bit     = |(b_q & (WIDTH'(1) << i_q));
        mul_first   = (i_q == '0);
        mul_sum     = mul_first ? '0 : bus.au_add_out;
        mul_ovf     = ovf_q | (!mul_first & bus.au_add_cout);
        mul_ovf_nxt = mul_ovf | (mul_bit & (|mul_sh[2*WIDTH-1:WIDTH]));
    end

    // Sequencer FSM with registered outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            au_in1_q    <= '0;
            au_in2_q    <= '0;
            res_data_q  <= '0;
            res_flags_q <= '0;
            res_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            wait_q      <= 1'b0;
            ovf_q       <= 1'b0;
            i_q         <= '0;
        end else begin
            unique case (state_q)
                IDLE: if (bus.in_valid) begin
                    op_q       <= bus.in_op;
                    a_q        <= bus.in_a;
                    b_q        <= bus.in_b;
                    in_ready_q <= 1'b0;
                    wait_q     <= 1'b0;
                    ovf_q      <= 1'b0;
                    i_q        <= '0;
                    state_q    <= (bus.in_op == OP_MUL) ? MUL_ISSUE : ISSUE;
                end
                ISSUE: if (is_logic) begin
                    res_data_q  <= lg_res;
                    res_flags_q <= {lg_res == '0, lg_res[MSB], 2'b00};
                    res_valid_q <= 1'b1;
                    state_q     <= DONE;
                end else begin
                    au_in1_q <= a_q;
                    au_in2_q <= (op_q == OP_INC) ? WIDTH'(1) : b_q;
                    state_q  <= WAIT;
                end
                WAIT: if (!wait_q) begin
                    wait_q <= 1'b1;
                end else begin
                    res_data_q  <= au_res;
                    res_flags_q <= {au_fres == '0, au_fres[MSB], au_c, au_v};
                    res_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                MUL_ISSUE: if (i_q == I_LAST) begin
                    res_data_q  <= mul_sum;
                    res_flags_q <= {mul_sum == '0, mul_sum[MSB],
                                    mul_ovf, mul_ovf};
                    res_valid_q <= 1'b1;
                    state_q     <= DONE;
                end else begin
                    ovf_q    <= mul_ovf_nxt;
                    au_in1_q <= mul_sum;
                    au_in2_q <= mul_bit ? mul_sh[WIDTH-1:0] : '0;
                    state_q  <= MUL_WAIT;
                end
                MUL_WAIT: begin
                    i_q     <= i_q + IW'(1);
                    state_q <= MUL_ISSUE;
                end
                DONE: if (bus.res_ready) begin
                    res_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.au_in1    = au_in1_q;
    assign bus.au_in2    = au_in2_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_flags = res_flags_q;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a registered AU model.
// Latency is counted in clock edges after the accept edge.
module tb_alu_op_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int n_chk = 0;
    int n_err = 0;

    alu_op_sequencer_if #(.WIDTH(8)) bus ();

    alu_op_sequencer #(.WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Registered adder/subtractor, one cycle latency
    always @(posedge clk) begin
        {bus.au_add_cout, bus.au_add_out} <= {1'b0, bus.au_in1} + {1'b0, bus.au_in2};
        bus.au_sub_out  <= bus.au_in1 - bus.au_in2;
        bus.au_sub_bout <= (bus.au_in1 < bus.au_in2);
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one op, wait for result, check latency/data/flags, then retire it
    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [7:0] a, input logic [7:0] b,
                          input int lat, input logic [7:0] d,
                          input logic [3:0] f);
        int cnt;
        @(negedge clk);
        chk({tag, ".rdy"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid  = 1'b1;
        bus.in_op     = op;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_a     = ~a;
        bus.in_b     = ~b;
        chk({tag, ".busy"}, 32'(bus.in_ready), 32'd0);
        cnt = 0;
        while (!bus.res_valid && cnt < 40) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        chk({tag, ".lat"}, 32'(cnt), 32'(lat));
        chk({tag, ".data"}, 32'(bus.res_data), 32'(d));
        chk({tag, ".flags"}, 32'(bus.res_flags), 32'(f));
        @(posedge clk);
        #1;
        chk({tag, ".retire"}, 32'({bus.res_valid, bus.in_ready}), 32'b01);
    endtask

    initial begin
        int cnt;
        bus.in_valid  = 1'b0;
        bus.in_op     = 3'd0;
        bus.in_a      = 8'd0;
        bus.in_b      = 8'd0;
        bus.res_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst.valid", 32'(bus.res_valid), 32'd0);
        chk("rst.data", 32'(bus.res_data), 32'd0);
        chk("rst.flags", 32'(bus.res_flags), 32'd0);
        chk("rst.au", 32'({bus.au_in1, bus.au_in2}), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst.rdy", 32'(bus.in_ready), 32'd1);

        // Directed op vectors: op, a, b, latency, data, {Z,N,C,V}
        run_op("add", 3'b000, 8'h7F, 8'h01, 3, 8'h80, 4'b0101);
        run_op("sub", 3'b001, 8'h05, 8'h07, 3, 8'hFE, 4'b0110);
        run_op("cmp", 3'b110, 8'h42, 8'h42, 3, 8'h42, 4'b1000);
        run_op("xor", 3'b100, 8'hF0, 8'hFF, 1, 8'h0F, 4'b0000);
        run_op("and", 3'b010, 8'hF0, 8'h3C, 1, 8'h30, 4'b0000);
        run_op("or",  3'b011, 8'h80, 8'h01, 1, 8'h81, 4'b0100);
        run_op("inc", 3'b101, 8'hFF, 8'h00, 3, 8'h00, 4'b1010);
        run_op("mul1", 3'b111, 8'h0D, 8'h0B, 17, 8'h8F, 4'b0100);
        run_op("mul2", 3'b111, 8'h20, 8'h10, 17, 8'h00, 4'b1011);

        // Backpressure: result held, new request ignored while DONE
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_op     = 3'b000;
        bus.in_a      = 8'h10;
        bus.in_b      = 8'h20;
        bus.res_ready = 1'b0;
        @(posedge clk);
        #1;
        bus.in_op = 3'b100;
        bus.in_a  = 8'h55;
        bus.in_b  = 8'hAA;
        cnt = 0;
        while (!bus.res_valid && cnt < 40) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        chk("hold.lat", 32'(cnt), 32'd3);
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("hold.state", 32'({bus.res_valid, bus.in_ready, bus.res_data,
                                   bus.res_flags}), 32'({2'b10, 8'h30, 4'b0000}));
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.res_ready = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
            chk("hold.drop", 32'({bus.res_valid, bus.in_ready}), 32'b01);
        end
        chk("hold.keep", 32'(bus.res_data), 32'h30);

        // Reset in the middle of a multiply
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_op    = 3'b111;
        bus.in_a     = 8'h0D;
        bus.in_b     = 8'h0B;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("mrst.out", 32'({bus.res_valid, bus.res_data, bus.res_flags}), 32'd0);
        chk("mrst.au", 32'({bus.au_in1, bus.au_in2}), 32'd0);
        chk("mrst.rdy", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        repeat (20) begin
            @(posedge clk);
            #1;
            chk("mrst.quiet", 32'({bus.res_valid, bus.in_ready}), 32'b01);
        end
        run_op("add2", 3'b000, 8'h01, 8'h02, 3, 8'h03, 4'b0000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
